// File: rtl/vec_fma_pkg.sv
// Shared types and helpers for the vector fused multiply/add engine.
//   vec_fma_state_t : sequencing FSM states
//   MODE_WRAP/SAT   : arithmetic mode encodings
//   sat_clamp/add   : saturating helpers on a wide signed carrier, clamped to w bits
package vec_fma_pkg;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StLoadD,
    StCompute,
    StOutput
  } vec_fma_state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Carrier width for the helpers; callers need 2*w + 2 <= MaxW.
  localparam int unsigned MaxW = 64;

  // Clamp x to the signed range of a w-bit value.
  function automatic logic signed [MaxW-1:0] sat_clamp(input logic signed [MaxW-1:0] x,
                                                       input int unsigned w);
    logic signed [MaxW-1:0] hi;
    logic signed [MaxW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic signed [MaxW-1:0] sat_add(input logic signed [MaxW-1:0] x,
                                                     input logic signed [MaxW-1:0] y,
                                                     input int unsigned w);
    return sat_clamp(x + y, w);
  endfunction

endpackage

// File: rtl/vec_fma_lane_pipe.sv
// Two-stage lane arithmetic, time-shared across lanes by the engine.
//   stage 1: p = (a*b) >>> FRAC, reduced to WIDTH (wrap or clamp)
//   stage 2: f = p + d - (b>>>1) - b[0], each step reduced to WIDTH
// Ports: clk_i, rst_i, issue_valid_i, mode_i, a_i, b_i, d_i in; f_o, res_valid_o out.
module vec_fma_lane_pipe
  import vec_fma_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  input  logic                    mode_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] d_i,
  output logic signed [WIDTH-1:0] f_o,
  output logic                    res_valid_o
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic signed [WIDTH-1:0]   p_d;

  logic signed [WIDTH-1:0]   p_q, d_q, b_q;
  logic                      mode_q, s1_valid_q;

  logic signed [WIDTH+1:0]   e_ext;
  logic signed [WIDTH-1:0]   e_sel;
  logic signed [WIDTH+1:0]   f_ext;
  logic signed [WIDTH-1:0]   f_d;

  logic signed [WIDTH-1:0]   f_q;
  logic                      s2_valid_q;

  always_comb begin
    prod    = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
    prod_sh = prod >>> FRAC;
    if (mode_i == MODE_SAT) p_d = WIDTH'(sat_clamp(MaxW'(prod_sh), WIDTH));
    else                    p_d = WIDTH'(prod_sh);
  end

  // Subtracting (b>>>1) and b[0] separately rounds b/2 towards +inf.
  always_comb begin
    e_ext = (WIDTH+2)'(p_q) + (WIDTH+2)'(d_q);
    if (mode_q == MODE_WRAP) e_sel = WIDTH'(e_ext);
    else                     e_sel = WIDTH'(sat_add(MaxW'(p_q), MaxW'(d_q), WIDTH));
    f_ext = (WIDTH+2)'(e_sel) - (WIDTH+2)'(b_q >>> 1) - (WIDTH+2)'(b_q[0]);
    if (mode_q == MODE_WRAP) f_d = WIDTH'(f_ext);
    else                     f_d = WIDTH'(sat_clamp(MaxW'(f_ext), WIDTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q        <= '0;
      d_q        <= '0;
      b_q        <= '0;
      mode_q     <= MODE_WRAP;
      s1_valid_q <= 1'b0;
      f_q        <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= issue_valid_i;
      if (issue_valid_i) begin
        p_q    <= p_d;
        d_q    <= d_i;
        b_q    <= b_i;
        mode_q <= mode_i;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) f_q <= f_d;
    end
  end

  assign f_o         = f_q;
  assign res_valid_o = s2_valid_q;

endmodule

// File: rtl/vec_fma_engine.sv
// Self-sequencing vector FMA engine: loads a, b, d vectors word by word over a
// valid/ready input stream, runs each lane through vec_fma_lane_pipe, then streams
// the results out with out_last_o on the final lane.
// Ports: clk_i, rst_i (sync, active high), mode_i, in_valid_i/in_ready_o/in_data_i,
//        out_valid_o/out_ready_i/out_data_o/out_last_o, busy_o.
module vec_fma_engine
  import vec_fma_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned FRAC  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int unsigned     IdxW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);
  localparam logic [IdxW-1:0] OneIdx  = IdxW'(1);

  vec_fma_state_t          state_q;
  logic [IdxW-1:0]         idx_q;   // load index, then issue index
  logic [IdxW-1:0]         oidx_q;  // write-back index, then output index
  logic                    issued_q;
  logic                    mode_q;
  logic                    in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [WIDTH-1:0]        out_data_q;
  logic signed [WIDTH-1:0] a_q [LANES];
  logic signed [WIDTH-1:0] b_q [LANES];
  logic signed [WIDTH-1:0] d_q [LANES];
  logic signed [WIDTH-1:0] f_q [LANES];

  logic                    in_fire, out_fire, issue_valid, res_valid;
  logic signed [WIDTH-1:0] res_f;

  assign in_fire     = in_valid_i && in_ready_q;
  assign out_fire    = out_valid_q && out_ready_i;
  assign issue_valid = (state_q == StCompute) && !issued_q;

  vec_fma_lane_pipe #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_pipe (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid),
    .mode_i        (mode_q),
    .a_i           (a_q[idx_q]),
    .b_i           (b_q[idx_q]),
    .d_i           (d_q[idx_q]),
    .f_o           (res_f),
    .res_valid_o   (res_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StLoadA;
      idx_q       <= '0;
      oidx_q      <= '0;
      issued_q    <= 1'b0;
      mode_q      <= MODE_WRAP;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        d_q[i] <= '0;
        f_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StLoadA: begin
          if (in_fire) begin
            a_q[idx_q] <= in_data_i;
            busy_q     <= 1'b1;
            if (idx_q == '0) mode_q <= mode_i;
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StLoadB;
            end else begin
              idx_q <= idx_q + OneIdx;
            end
          end
        end
        StLoadB: begin
          if (in_fire) begin
            b_q[idx_q] <= in_data_i;
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StLoadD;
            end else begin
              idx_q <= idx_q + OneIdx;
            end
          end
        end
        StLoadD: begin
          if (in_fire) begin
            d_q[idx_q] <= in_data_i;
            if (idx_q == LastIdx) begin
              idx_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= StCompute;
            end else begin
              idx_q <= idx_q + OneIdx;
            end
          end
        end
        StCompute: begin
          if (issue_valid) begin
            if (idx_q == LastIdx) begin
              idx_q    <= '0;
              issued_q <= 1'b1;
            end else begin
              idx_q <= idx_q + OneIdx;
            end
          end
          // Results return in issue order, so oidx_q doubles as the write pointer.
          if (res_valid) begin
            f_q[oidx_q] <= res_f;
            if (oidx_q == LastIdx) begin
              oidx_q      <= '0;
              issued_q    <= 1'b0;
              state_q     <= StOutput;
              out_valid_q <= 1'b1;
              out_data_q  <= f_q[0];
              out_last_q  <= 1'b0;
            end else begin
              oidx_q <= oidx_q + OneIdx;
            end
          end
        end
        StOutput: begin
          if (out_fire) begin
            if (oidx_q == LastIdx) begin
              oidx_q      <= '0;
              state_q     <= StLoadA;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              oidx_q     <= oidx_q + OneIdx;
              out_data_q <= f_q[oidx_q + OneIdx];
              out_last_q <= (oidx_q + OneIdx) == LastIdx;
            end
          end
        end
        default: state_q <= StLoadA;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_vec_fma_engine.sv
// Directed bench for vec_fma_engine: a FRAC=0 instance and a FRAC=4 instance share
// all inputs and run in lockstep; results are checked against hand-computed vectors.
module tb_vec_fma_engine;

  localparam int unsigned W = 8;
  localparam int unsigned L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, mode, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_last, busy;
  logic [W-1:0] out_data;
  logic         in_ready_fx, out_valid_fx, out_last_fx, busy_fx;
  logic [W-1:0] out_data_fx;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [31:0] va [L];
  logic signed [31:0] vb [L];
  logic signed [31:0] vd [L];
  logic signed [31:0] ef [L];
  logic signed [31:0] ef_fx [L];
  bit                 chk_fx;

  vec_fma_engine #(.WIDTH(W), .LANES(L), .FRAC(0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .busy_o      (busy)
  );

  vec_fma_engine #(.WIDTH(W), .LANES(L), .FRAC(4)) dut_fx (
    .clk_i       (clk),
    .rst_i       (rst),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_fx),
    .in_data_i   (in_data),
    .out_valid_o (out_valid_fx),
    .out_ready_i (out_ready),
    .out_data_o  (out_data_fx),
    .out_last_o  (out_last_fx),
    .busy_o      (busy_fx)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_word(input logic [W-1:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Mode flips right after a[0] is accepted; the latched mode must be used.
  task automatic send_vector(input logic m, input bit bubbles);
    logic signed [31:0] w;
    mode = m;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < L; i++) begin
        w = (s == 0) ? va[i] : (s == 1) ? vb[i] : vd[i];
        if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk);
        send_word(w[W-1:0]);
        if (s == 0 && i == 0) mode = ~m;
      end
    end
  endtask

  task automatic check_latency();
    for (int k = 0; k < L + 2; k++) begin
      check_eq("lat_low", out_valid, 0);
      check_eq("lat_in_ready", in_ready, 0);
      @(negedge clk);
    end
    check_eq("lat_rise", out_valid, 1);
  endtask

  task automatic recv_vector(input string tag, input int stall_lane);
    int t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < L; i++) begin
      if (i == stall_lane) begin
        out_ready = 1'b0;
        repeat (3) begin
          check_eq({tag, "_stall_valid"}, out_valid, 1);
          check_eq({tag, "_stall_data"}, $signed(out_data), ef[i]);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      check_eq({tag, "_valid"}, out_valid, 1);
      check_eq({tag, "_data"}, $signed(out_data), ef[i]);
      check_eq({tag, "_last"}, out_last, (i == L - 1) ? 1 : 0);
      check_eq({tag, "_busy"}, busy, 1);
      check_eq({tag, "_in_ready"}, in_ready, 0);
      if (chk_fx) check_eq({tag, "_fx_data"}, $signed(out_data_fx), ef_fx[i]);
      @(negedge clk);
    end
    check_eq({tag, "_end_valid"}, out_valid, 0);
    check_eq({tag, "_end_busy"}, busy, 0);
    check_eq({tag, "_end_in_ready"}, in_ready, 1);
  endtask

  task automatic load_basic();
    va = '{2, 3, -4, 5};
    vb = '{3, 4, 5, -6};
    vd = '{1, 1, 1, 1};
    ef = '{5, 11, -22, -26};
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    chk_fx    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", $signed(out_data), 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);

    // Basic vector with exact latency
    load_basic();
    send_vector(1'b0, 1'b0);
    check_latency();
    recv_vector("basic", -1);

    // Backpressure while f[1] is presented
    send_vector(1'b0, 1'b0);
    recv_vector("bp", 1);

    // Input bubbles
    send_vector(1'b0, 1'b1);
    recv_vector("bub", -1);

    // Reset in LOAD_B after 5 accepted words
    mode = 1'b0;
    for (int i = 0; i < 4; i++) send_word(8'd77);
    send_word(8'd33);
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_busy", busy, 0);
    send_vector(1'b0, 1'b0);
    recv_vector("rst", -1);

    // Overflow, wrap then saturate
    va = '{16, 16, 16, 16};
    vb = '{16, 16, 16, 16};
    vd = '{0, 0, 0, 0};
    ef = '{-8, -8, -8, -8};
    send_vector(1'b0, 1'b0);
    recv_vector("ovf_wrap", -1);
    ef = '{119, 119, 119, 119};
    send_vector(1'b1, 1'b0);
    recv_vector("ovf_sat", -1);

    // Saturation at both rails, clamping p, e and f
    va = '{16, -16, 10, 1};
    vb = '{16, 16, 10, -3};
    vd = '{0, 0, 100, -128};
    ef = '{119, -128, 122, -127};
    send_vector(1'b1, 1'b1);
    recv_vector("sat_mix", -1);

    // Fixed point: FRAC=4 instance gives 72, FRAC=0 instance wraps to -24
    va = '{32, 32, 32, 32};
    vb = '{48, 48, 48, 48};
    vd = '{0, 0, 0, 0};
    ef = '{-24, -24, -24, -24};
    ef_fx = '{72, 72, 72, 72};
    chk_fx = 1'b1;
    send_vector(1'b0, 1'b0);
    recv_vector("frac", -1);
    chk_fx = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vec_fma_engine.md
# vec_fma_engine

Parametrised, self-sequencing successor to the fixed 4-lane 8-bit vector datapath. It accepts three operand vectors a, b and d over a single valid/ready input stream. For each lane it computes f = trunc(a·b) + d − (b>>>1) − b[0] through a two-stage multiply/add pipeline. The result vector is returned on a valid/ready output stream. The external controller no longer drives per-register enables, and the block adds a wrap/saturate arithmetic mode and a fixed-point product shift.

## Interface
- WIDTH, 8: operand and result width, two's-complement signed.
- LANES, 4: vector length, ≥ 2.
- FRAC, 0: arithmetic right shift applied to the 2·WIDTH product, 0 ≤ FRAC < WIDTH.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = wrap (modular), 1 = saturate; latched when a[0] is accepted.
- in_valid  in  1  in_data carries an operand word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WIDTH  operand word, signed.
- out_valid  out  1  out_data carries a result word.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  result f[i], signed.
- out_last  out  1  high with f[LANES−1].
- busy  out  1  high in every state except LOAD_A while lane count is 0.

## Operation
- **FSM states:** LOAD_A → LOAD_B → LOAD_D → COMPUTE → OUTPUT → LOAD_A.
- **Load states:**
  - in_ready = 1 only in LOAD_A, LOAD_B and LOAD_D.
  - A word transfers when in_valid && in_ready, into a[idx], b[idx] or d[idx].
  - idx increments per transfer; at idx = LANES−1 it wraps to 0 and the FSM advances.
  - Bubbles (in_valid = 0) stall without side effects.
- **COMPUTE:**
  - Issues lanes 0..LANES−1, one per cycle, into stage 1: p = (a·b) >>> FRAC, at full 2·WIDTH width, then reduced to WIDTH.
  - Stage 2: e = p + d; f = e − (b>>>1) − b[0]. This equals e − ceil(b/2).
  - f is written to f[lane].
- **Mode 0:** every reduction keeps the low WIDTH bits.
- **Mode 1:** p, e and f each clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1], with intermediates computed at WIDTH+2 bits.
- **OUTPUT:**
  - out_data = f[oidx], out_valid = 1.
  - oidx advances on out_valid && out_ready.
  - After f[LANES−1] transfers, the FSM returns to LOAD_A and out_valid drops the same cycle.
- Input and output phases never overlap; in_ready = 0 throughout COMPUTE and OUTPUT.
- mode changes after a[0] is accepted have no effect until the next vector.

## Timing
- **Reset values:**
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - Internal: state = LOAD_A, all indices 0, all operand and result registers 0.
- **rst mid-operation** (any state) discards all partial vectors. The next accepted word is a[0].
- **Latency:** out_valid first rises exactly LANES+2 cycles after the edge that accepts d[LANES−1]. That is LANES issue cycles plus one pipeline drain cycle plus the state change.
- **Output hold:** out_data and out_last are registered and stay stable while out_valid && !out_ready.
- **Throughput:** minimum 3·LANES + (LANES+2) + LANES cycles per vector with no stalls.
- **Simultaneous events:** rst has priority over any handshake in the same cycle.

## Structure
- **Package vec_fma_pkg:**
  - State enum vec_fma_state_t.
  - Saturating add and clamp functions parametrised by width.
  - Mode constants MODE_WRAP and MODE_SAT.
- **Sub-module vec_fma_lane_pipe:**
  - The two-stage arithmetic pipeline with inputs a, b, d, mode and issue-valid.
  - Outputs f and result-valid.
  - Instantiated once, time-shared across lanes.

## Test plan
- **Basic (WIDTH=8, LANES=4, FRAC=0, mode 0):** a={2,3,−4,5}, b={3,4,5,−6}, d={1,1,1,1} → f={5,11,−22,−26}, out_last only with −26.
- **Overflow:** a=16, b=16, d=0 in every lane → mode 0 gives f=−8; mode 1 gives f=119 (p clamps to 127).
- **Backpressure:** hold out_ready = 0 for 3 cycles while f[1] is presented → out_data stays 11 with out_valid high, no skip or duplicate.
- **Input bubbles:** insert random in_valid = 0 gaps → same results as the basic case; busy stays 1 until the final output transfer.
- **Reset mid-load:** assert rst after 5 accepted words (in LOAD_B) → in_ready = 1, out_valid = 0; a fresh full vector then yields exactly the basic-case results.
- **Fixed point (FRAC=4):** a=32, b=48, d=0, mode 0 → p=96, f=96−24−0=72 per lane.
